// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-style to AXI bridge: FSM states, access
// size codes and the fixed AXI burst attributes used for single beats.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_RESP = 3'd4
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI bus between the bridge (master) and the memory system (slave).
// Every channel uses valid/ready: a beat transfers on the rising edge where both are high.
interface sram_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_bridge_wstrb_gen.sv
// Byte-lane write strobe from access size and the low address bits.
module wstrb_gen
    import sram_axi_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// SRAM-style instruction/data request ports onto a single-beat AXI master,
// one transaction in flight, data requests take priority over instruction fetches.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID_INST = 4'd0,
    parameter logic [3:0] AXI_ID_DATA = 4'd1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [31:0]   inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,
    output bridge_state_t state_dbg,
    sram_axi_bridge_if.master axi
);

    bridge_state_t state_q, state_n;
    logic        owner_data_q, owner_data_n;
    logic [31:0] addr_q, addr_n;
    logic [1:0]  size_q, size_n;
    logic [31:0] wdata_q, wdata_n;
    logic        arvalid_q, arvalid_n;
    logic        rready_q, rready_n;
    logic        awvalid_q, awvalid_n;
    logic        wvalid_q, wvalid_n;
    logic        bready_q, bready_n;
    logic        inst_ok_q, inst_ok_n;
    logic        data_ok_q, data_ok_n;
    logic [31:0] rdata_q, rdata_n;
    logic        ok_busy;
    logic        unused_resp;

    // The cycle carrying a data_ok pulse is still part of the finished access.
    assign ok_busy = inst_ok_q | data_ok_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_n;
            owner_data_q <= owner_data_n;
            addr_q       <= addr_n;
            size_q       <= size_n;
            wdata_q      <= wdata_n;
            arvalid_q    <= arvalid_n;
            rready_q     <= rready_n;
            awvalid_q    <= awvalid_n;
            wvalid_q     <= wvalid_n;
            bready_q     <= bready_n;
            inst_ok_q    <= inst_ok_n;
            data_ok_q    <= data_ok_n;
            rdata_q      <= rdata_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        owner_data_n = owner_data_q;
        addr_n       = addr_q;
        size_n       = size_q;
        wdata_n      = wdata_q;
        arvalid_n    = arvalid_q;
        rready_n     = rready_q;
        awvalid_n    = awvalid_q;
        wvalid_n     = wvalid_q;
        bready_n     = bready_q;
        inst_ok_n    = 1'b0;
        data_ok_n    = 1'b0;
        rdata_n      = rdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!ok_busy && data_req) begin
                    data_addr_ok = 1'b1;
                    owner_data_n = 1'b1;
                    addr_n       = data_addr;
                    size_n       = data_size;
                    wdata_n      = data_wdata;
                    if (data_wr) begin
                        state_n   = S_WR_ADDR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = S_RD_ADDR;
                        arvalid_n = 1'b1;
                    end
                end else if (!ok_busy && inst_req) begin
                    inst_addr_ok = 1'b1;
                    owner_data_n = 1'b0;
                    addr_n       = inst_addr;
                    size_n       = SIZE_WORD;
                    wdata_n      = '0;
                    state_n      = S_RD_ADDR;
                    arvalid_n    = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (axi.rvalid) begin
                    rready_n = 1'b0;
                    rdata_n  = axi.rdata;
                    if (owner_data_q) data_ok_n = 1'b1;
                    else              inst_ok_n = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            S_WR_ADDR: begin
                // AW and W complete independently; leave only once both have.
                if (axi.awready) awvalid_n = 1'b0;
                if (axi.wready)  wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (axi.bvalid) begin
                    bready_n  = 1'b0;
                    data_ok_n = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    wstrb_gen u_wstrb_gen (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wstrb   (axi.wstrb)
    );

    assign axi.arid    = owner_data_q ? AXI_ID_DATA : AXI_ID_INST;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = axi_size(size_q);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awid    = AXI_ID_DATA;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = axi_size(size_q);
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = rdata_q;
    assign data_rdata   = rdata_q;
    assign state_dbg    = state_q;

    // Response codes and IDs carry nothing this bridge acts on.
    assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: an AXI slave with configurable wait states, a
// byte-lane memory reference model and a read-data scoreboard.
module tb_sram_axi_bridge;
    import sram_axi_bridge_pkg::*;

    logic          clk;
    logic          reset;
    logic          inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0]   inst_addr, inst_rdata;
    logic          data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]    data_size;
    logic [31:0]   data_addr, data_wdata, data_rdata;
    bridge_state_t state_dbg;

    sram_axi_bridge_if axi_bus();

    sram_axi_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .state_dbg    (state_dbg),
        .axi          (axi_bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] slave_mem [int unsigned];
    logic [31:0] ar_addr_q[$], ar_info_q[$], aw_addr_q[$], aw_info_q[$], w_data_q[$], w_info_q[$];
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    int aw_extra, w_extra, aw_w_skew, data_ok_cnt;
    logic w_pending_at_aw;
    logic [31:0] last_rdata;
    logic [3:0]  last_wstrb;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fill_word(input int unsigned w);
        return 32'(w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ref_get(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : fill_word(w);
    endfunction

    function automatic logic [31:0] slave_get(input int unsigned w);
        return slave_mem.exists(w) ? slave_mem[w] : fill_word(w);
    endfunction

    // Bytes covered by an access: the size-aligned group containing addr.
    function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [31:0] addr);
        int nbytes, lo;
        logic [3:0] m;
        nbytes = 1 << size;
        lo = (int'(addr % 4) / nbytes) * nbytes;
        m = '0;
        for (int b = 0; b < 4; b++) if (b >= lo && b < lo + nbytes) m[b] = 1'b1;
        return m;
    endfunction

    function automatic void model_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        logic [3:0] m;
        logic [31:0] w;
        m = model_mask(size, addr);
        w = ref_get(addr / 4);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[addr / 4] = w;
    endfunction

    // ---------------- AXI slave: read side ----------------
    initial begin
        int ph, cnt;
        logic [31:0] rd_addr;
        ph = 0; cnt = 0; rd_addr = '0;
        axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0;
        axi_bus.rid = '0; axi_bus.rresp = '0; axi_bus.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; ph = 0; cnt = 0;
            end else begin
                case (ph)
                    0: if (axi_bus.arvalid) begin
                        if (cnt >= ar_wait) begin
                            axi_bus.arready = 1'b1;
                            ar_addr_q.push_back(axi_bus.araddr);
                            ar_info_q.push_back({15'd0, axi_bus.arid, axi_bus.arsize, axi_bus.arlen, axi_bus.arburst});
                            rd_addr = axi_bus.araddr;
                            ph = 1; cnt = 0;
                        end else cnt++;
                    end
                    1: begin
                        axi_bus.arready = 1'b0;
                        if (cnt >= r_wait) begin
                            axi_bus.rvalid = 1'b1;
                            axi_bus.rdata  = slave_get(rd_addr / 4);
                            axi_bus.rid    = 4'($urandom);
                            axi_bus.rresp  = 2'($urandom);
                            axi_bus.rlast  = 1'b1;
                            ph = 2;
                        end else cnt++;
                    end
                    default: begin
                        axi_bus.rvalid = 1'b0; axi_bus.rdata = $urandom; ph = 0; cnt = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- AXI slave: write side ----------------
    initial begin
        int aph, wph, bph, acnt, wcnt, bcnt;
        logic [31:0] wr_addr, wr_data, word;
        logic [3:0]  wr_strb;
        aph = 0; wph = 0; bph = 0; acnt = 0; wcnt = 0; bcnt = 0;
        wr_addr = '0; wr_data = '0; wr_strb = '0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
        axi_bus.bid = '0; axi_bus.bresp = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
                aph = 0; wph = 0; bph = 0; acnt = 0; wcnt = 0; bcnt = 0;
            end else begin
                if (aph == 0 && wph == 0 && axi_bus.awvalid != axi_bus.wvalid) aw_w_skew++;
                case (aph)
                    0: if (axi_bus.awvalid) begin
                        if (acnt >= aw_wait) begin
                            axi_bus.awready = 1'b1;
                            aw_addr_q.push_back(axi_bus.awaddr);
                            aw_info_q.push_back({15'd0, axi_bus.awid, axi_bus.awsize, axi_bus.awlen, axi_bus.awburst});
                            wr_addr = axi_bus.awaddr;
                            aph = 1;
                        end else acnt++;
                    end
                    1: begin
                        axi_bus.awready = 1'b0;
                        if (axi_bus.awvalid) aw_extra++;
                        w_pending_at_aw = axi_bus.wvalid;
                        aph = 2;
                    end
                    default: ;
                endcase
                case (wph)
                    0: if (axi_bus.wvalid) begin
                        if (wcnt >= w_wait) begin
                            axi_bus.wready = 1'b1;
                            w_data_q.push_back(axi_bus.wdata);
                            w_info_q.push_back({27'd0, axi_bus.wlast, axi_bus.wstrb});
                            wr_data = axi_bus.wdata;
                            wr_strb = axi_bus.wstrb;
                            wph = 1;
                        end else wcnt++;
                    end
                    1: begin
                        axi_bus.wready = 1'b0;
                        if (axi_bus.wvalid) w_extra++;
                        wph = 2;
                    end
                    default: ;
                endcase
                if (aph == 2 && wph == 2) begin
                    if (bph == 0) begin
                        if (bcnt >= b_wait) begin
                            axi_bus.bvalid = 1'b1;
                            axi_bus.bid    = 4'($urandom);
                            axi_bus.bresp  = 2'($urandom);
                            word = slave_get(wr_addr / 4);
                            for (int b = 0; b < 4; b++) if (wr_strb[b]) word[8*b +: 8] = wr_data[8*b +: 8];
                            slave_mem[wr_addr / 4] = word;
                            bph = 1;
                        end else bcnt++;
                    end else begin
                        axi_bus.bvalid = 1'b0;
                        aph = 0; wph = 0; bph = 0; acnt = 0; wcnt = 0; bcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && data_data_ok) data_ok_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic set_waits(input int a, input int r, input int aw, input int w, input int b);
        ar_wait = a; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b;
    endtask

    task automatic run_access(input bit is_inst, input bit wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input bit check_lat, output int tries);
        int cyc;
        bit got;
        logic [31:0] exp_info;
        @(negedge clk);
        if (is_inst) begin
            inst_req = 1'b1; inst_addr = addr;
        end else begin
            data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
        end
        tries = 0; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (is_inst ? inst_addr_ok : data_addr_ok) begin got = 1'b1; break; end
            @(negedge clk);
            tries++;
        end
        check_val("addr_ok", 32'(got), 32'd1);
        if (!wr) exp_q.push_back(ref_get(addr / 4));
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        cyc = 1; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (is_inst ? inst_data_ok : data_data_ok) begin got = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        check_val("data_ok", 32'(got), 32'd1);
        if (!wr && exp_q.size() > 0) begin
            last_rdata = is_inst ? inst_rdata : data_rdata;
            check_val("rdata", last_rdata, exp_q.pop_front());
        end
        if (got) begin
            if (check_lat) check_val("latency", cyc, 32'd3);
            if (is_inst) inst_req = 1'b1;
            else begin data_req = 1'b1; data_wr = 1'b0; end
            #1;
            check_val("busy_addr_ok", 32'(is_inst ? inst_addr_ok : data_addr_ok), 32'd0);
            inst_req = 1'b0; data_req = 1'b0;
            @(negedge clk);
            check_val("ok_pulse", 32'(is_inst ? inst_data_ok : data_data_ok), 32'd0);
        end
        if (!wr) begin
            check_val("ar_count", ar_addr_q.size(), 32'd1);
            if (ar_addr_q.size() > 0) begin
                exp_info = {15'd0, is_inst ? 4'd0 : 4'd1, is_inst ? 3'd2 : {1'b0, size}, 8'd0, 2'b01};
                check_val("araddr", ar_addr_q.pop_front(), addr);
                check_val("ar_fields", ar_info_q.pop_front(), exp_info);
            end
        end else begin
            check_val("aw_count", aw_addr_q.size(), 32'd1);
            check_val("w_count", w_data_q.size(), 32'd1);
            if (aw_addr_q.size() > 0) begin
                exp_info = {15'd0, 4'd1, {1'b0, size}, 8'd0, 2'b01};
                check_val("awaddr", aw_addr_q.pop_front(), addr);
                check_val("aw_fields", aw_info_q.pop_front(), exp_info);
            end
            if (w_data_q.size() > 0) begin
                exp_info = w_info_q.pop_front();
                last_wstrb = exp_info[3:0];
                check_val("wdata", w_data_q.pop_front(), wdata);
                check_val("wstrb_wlast", exp_info, {27'd0, 1'b1, model_mask(size, addr)});
            end
            model_write(size, addr, wdata);
        end
        ar_addr_q.delete(); ar_info_q.delete();
        aw_addr_q.delete(); aw_info_q.delete(); w_data_q.delete(); w_info_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int tries, cnt0, early, nb, off;
        bit got, is_inst, wr, zero;
        logic [1:0] size;
        logic [31:0] addr;

        reset = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        aw_extra = 0; w_extra = 0; aw_w_skew = 0; data_ok_cnt = 0; w_pending_at_aw = 1'b0;
        last_rdata = '0; last_wstrb = '0;
        set_waits(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_ctrl", 32'({axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid, axi_bus.wvalid,
                                   axi_bus.bready, inst_data_ok, data_data_ok}), 32'd0);
        check_val("rst_addr", axi_bus.araddr, 32'd0);
        check_val("rst_wdata", axi_bus.wdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Instruction fetch with two wait cycles on R, first cycle after reset.
        slave_mem[32'h1FC00000 / 4] = 32'h3C1D0001;
        ref_mem[32'h1FC00000 / 4]   = 32'h3C1D0001;
        set_waits(0, 2, 0, 0, 0);
        run_access(1'b1, 1'b0, 2'd2, 32'h1FC00000, 32'd0, 1'b0, tries);
        check_val("first_accept", tries, 32'd0);
        check_val("inst_word", last_rdata, 32'h3C1D0001);

        // Zero-wait read latency.
        set_waits(0, 0, 0, 0, 0);
        run_access(1'b0, 1'b0, 2'd2, 32'h00001000, 32'd0, 1'b1, tries);

        // Sub-word stores and read-back.
        run_access(1'b0, 1'b1, 2'd0, 32'h00001003, 32'hAB000000, 1'b1, tries);
        check_val("byte_wstrb", 32'(last_wstrb), 32'h8);
        run_access(1'b0, 1'b1, 2'd1, 32'h00001002, 32'hCDEF0000, 1'b1, tries);
        check_val("half_wstrb", 32'(last_wstrb), 32'hC);
        run_access(1'b0, 1'b0, 2'd2, 32'h00001000, 32'd0, 1'b1, tries);

        // AW accepted two cycles ahead of W.
        set_waits(0, 0, 0, 2, 1);
        aw_extra = 0;
        cnt0 = data_ok_cnt;
        run_access(1'b0, 1'b1, 2'd2, 32'h00001008, 32'h11223344, 1'b0, tries);
        @(negedge clk);
        check_val("aw_no_dup", aw_extra, 32'd0);
        check_val("w_after_aw", 32'(w_pending_at_aw), 32'd1);
        check_val("one_data_ok", data_ok_cnt - cnt0, 32'd1);

        // Simultaneous requests: data first, then instruction.
        set_waits(0, 0, 0, 0, 0);
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h1FC00000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h00001004;
        #1;
        check_val("both_data_ok", 32'(data_addr_ok), 32'd1);
        check_val("both_inst_ok", 32'(inst_addr_ok), 32'd0);
        @(negedge clk);
        data_req = 1'b0;
        got = 1'b0; early = 0;
        for (int i = 0; i < 50; i++) begin
            if (data_data_ok) begin got = 1'b1; break; end
            if (inst_addr_ok) early++;
            @(negedge clk);
        end
        check_val("both_data_done", 32'(got), 32'd1);
        check_val("both_data_rdata", data_rdata, ref_get(32'h00001004 / 4));
        check_val("inst_held_off", early, 32'd0);
        check_val("inst_busy", 32'(inst_addr_ok), 32'd0);
        @(negedge clk);
        check_val("inst_after", 32'(inst_addr_ok), 32'd1);
        @(negedge clk);
        inst_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (inst_data_ok) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_val("both_inst_done", 32'(got), 32'd1);
        check_val("both_inst_rdata", inst_rdata, 32'h3C1D0001);
        check_val("both_ar_order", ar_addr_q.size() > 1 ? ar_addr_q[1] : 32'd0, 32'h1FC00000);
        ar_addr_q.delete(); ar_info_q.delete();

        // Reset while waiting for read data.
        set_waits(0, 20, 0, 0, 0);
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h1FC00000;
        #1 check_val("rst_test_accept", 32'(inst_addr_ok), 32'd1);
        @(negedge clk);
        inst_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (axi_bus.rready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_val("in_rd_data", 32'(got), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_ctrl", 32'({axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid, axi_bus.wvalid,
                                      axi_bus.bready, inst_data_ok, data_data_ok}), 32'd0);
        check_val("midrst_addr", axi_bus.araddr, 32'd0);
        check_val("midrst_rdata", inst_rdata, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        ar_addr_q.delete(); ar_info_q.delete();
        set_waits(0, 0, 0, 0, 0);
        run_access(1'b1, 1'b0, 2'd2, 32'h1FC00000, 32'd0, 1'b1, tries);
        check_val("post_rst_accept", tries, 32'd0);

        // Randomized mix over a small window so reads hit earlier stores.
        for (int n = 0; n < 40; n++) begin
            is_inst = ($urandom_range(0, 2) == 0);
            wr = !is_inst && ($urandom_range(0, 1) == 1);
            size = is_inst ? 2'd2 : 2'($urandom_range(0, 2));
            nb = 1 << size;
            off = (int'($urandom_range(0, 3)) / nb) * nb;
            addr = 32'h00002000 + 32'($urandom_range(0, 15) * 4) + 32'(off);
            zero = (n % 4 == 0);
            if (zero) set_waits(0, 0, 0, 0, 0);
            else set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3));
            run_access(is_inst, wr, size, addr, $urandom, zero, tries);
        end

        @(negedge clk);
        check_val("aw_w_together", aw_w_skew, 32'd0);
        check_val("aw_extra_total", aw_extra, 32'd0);
        check_val("w_extra_total", w_extra, 32'd0);
        check_val("exp_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter AXI_ID_INST, default 4'd0, SHALL be the ARID used for instruction reads.
REQ-002 Parameter AXI_ID_DATA, default 4'd1, SHALL be the ARID/AWID used for data accesses.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 inst_req  input  1  SHALL be the instruction read request.
REQ-006 inst_addr  input  32  SHALL be the instruction address (already physical).
REQ-007 inst_addr_ok / inst_data_ok  output  1 each  SHALL be the request-accepted and data-returned pulses.
REQ-008 inst_rdata  output  32  SHALL be the instruction word, valid with inst_data_ok.
REQ-009 data_req, data_wr  input  1 each  SHALL be the data request and write-enable (1 = store).
REQ-010 data_size  input  2  SHALL be the access size: 0 = byte, 1 = half, 2 = word.
REQ-011 data_addr, data_wdata  input  32 each  SHALL be the physical address and store data (store data lane-aligned).
REQ-012 data_addr_ok / data_data_ok  output  1 each; data_rdata  output  32  SHALL mirror the instruction-side meanings.
REQ-013 AR channel: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid  out; arready  in.
REQ-014 R channel: rid 4, rdata 32, rresp 2, rlast, rvalid  in; rready  out.
REQ-015 AW/W channels: awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb 4, wlast, wvalid  out; awready, wready  in.
REQ-016 B channel: bid 4, bresp 2, bvalid  in; bready  out.

Function
REQ-017 The bridge SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, with one outstanding transaction.
REQ-018 In IDLE with data_req=1: pulse data_addr_ok this cycle, latch addr/size/wdata, go to WR_ADDR if data_wr else RD_ADDR.
REQ-019 In IDLE with only inst_req=1: pulse inst_addr_ok, latch inst_addr, go to RD_ADDR. Simultaneous requests: data wins; inst_addr_ok stays 0.
REQ-020 addr_ok SHALL be 0 in every non-IDLE state.
REQ-021 RD_ADDR: arvalid=1 until arready; then RD_DATA. arlen=0, arburst=2'b01, arsize={1'b0,size} (inst: 3'd2).
REQ-022 RD_DATA: rready=1; on rvalid, pulse owner's data_ok with rdata for one cycle, then IDLE.
REQ-023 WR_ADDR: awvalid and wvalid SHALL assert together; each drops independently on its ready; once both handshakes are done, go to WR_RESP.
REQ-024 wstrb: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?4'b1100:4'b0011; word -> 4'b1111. wlast=1.
REQ-025 WR_RESP: bready=1; on bvalid, pulse data_data_ok for one cycle, then IDLE.
REQ-026 A new request SHALL be accepted no earlier than the cycle after data_ok (minimum 4 cycles per access with zero-wait slave).
REQ-027 rresp/bresp/rid/bid SHALL be ignored; misalignment checking is done upstream.
REQ-028 Outputs SHALL be registered except addr_ok, which is combinational from IDLE and req.

Reset
REQ-029 On reset assertion, any cycle including mid-transaction: state = IDLE; all valid/ready/ok outputs = 0; latched address, data and size = 0.
REQ-030 The first request SHALL be acceptable in the first cycle after reset deasserts.

Structure
REQ-031 State encoding, size codes and AXI constants (burst INCR, len 0) SHALL live in a shared bridge package.
REQ-032 A single sub-module, wstrb_gen (size + addr[1:0] -> wstrb), SHALL be used; everything else stays in one FSM.

Verification
REQ-033 Inst read 0x1FC00000, slave returns rdata 0x3C1D0001 after 2 wait cycles -> inst_data_ok single pulse with 0x3C1D0001.
REQ-034 inst_req and data_req (read 0x00001004) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; data serviced first, inst accepted after.
REQ-035 Byte store to 0x00001003, wdata 0xAB000000 -> wstrb 4'b1000; half store to 0x00001002 -> 4'b1100; data_data_ok after bvalid.
REQ-036 awready two cycles before wready -> awvalid drops first; no duplicate AW handshake; exactly one data_data_ok.
REQ-037 Reset asserted while in RD_DATA -> all outputs 0 immediately; the next inst_req after release is accepted in IDLE.
